load_store_unit: RTL

Data-side load/store unit between the core's memory stage and the single-port word RAM. Accepts one RISC-V load or store request at a time, performs byte/halfword lane selection and sign/zero extension for loads, and does read-modify-write for sub-word stores, since the RAM only writes whole 32-bit words. Detects misaligned, illegal and out-of-range accesses and reports them without touching memory.

---
 rtl/load_store_unit.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Data-side load/store unit: one request at a time against a single-port word RAM.
// Sub-word stores use a read-modify-write through the MERGE state; loads extend in LOAD.
module load_store_unit #(
  parameter int LEN = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [2:0]  reqFunct3,
  input  logic [31:0] reqAddress,
  input  logic [31:0] reqData,
  output logic        respValid,
  output logic [31:0] respData,
  output logic        respFault,
  output logic        memEnable,
  output logic [31:0] memAddress,
  output logic [31:0] memDataIn,
  output logic        memWriteEnable,
  input  logic [31:0] memDataOut,
  output logic [1:0]  debugState
);

  // Handshake: a request transfers on a rising edge where reqValid && reqReady;
  // reqReady is high only in IDLE outside reset, and respValid is a single-cycle pulse.
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, MERGE = 2'd2, RESP = 2'd3} state_t;

  localparam logic [29:0] LEN_WORDS = 30'(LEN);

  state_t      state, state_next;
  logic [31:0] addr_q, data_q;
  logic [2:0]  funct3_q;
  logic        write_q;
  logic        accept, fault, illegal_op, misaligned, out_of_range, is_sw;
  logic [31:0] load_word, load_result, merge_word;

  assign accept     = reqValid && (state == IDLE) && !reset;
  assign is_sw      = reqWrite && (reqFunct3 == 3'b010);
  assign respValid  = (state == RESP);
  assign debugState = state;

  always_comb begin
    if (reqWrite) illegal_op = (reqFunct3 > 3'b010);
    else          illegal_op = (reqFunct3 == 3'b011) || (reqFunct3[2:1] == 2'b11);
  end

  assign misaligned   = ((reqFunct3[1:0] == 2'b01) && reqAddress[0]) ||
                        ((reqFunct3[1:0] == 2'b10) && (reqAddress[1:0] != 2'b00));
  assign out_of_range = (reqAddress[31:2] >= LEN_WORDS);
  assign fault        = illegal_op || misaligned || out_of_range;

  // Shifting by the byte offset brings the addressed lane down to bit 0.
  assign load_word = memDataOut >> {addr_q[1:0], 3'b000};

  always_comb begin
    case (funct3_q)
      3'b000:  load_result = {{24{load_word[7]}}, load_word[7:0]};
      3'b001:  load_result = {{16{load_word[15]}}, load_word[15:0]};
      3'b100:  load_result = {24'h0, load_word[7:0]};
      3'b101:  load_result = {16'h0, load_word[15:0]};
      default: load_result = memDataOut;
    endcase
  end

  always_comb begin
    merge_word = memDataOut;
    if (funct3_q[1:0] == 2'b00) begin
      case (addr_q[1:0])
        2'd0: merge_word[7:0]   = data_q[7:0];
        2'd1: merge_word[15:8]  = data_q[7:0];
        2'd2: merge_word[23:16] = data_q[7:0];
        2'd3: merge_word[31:24] = data_q[7:0];
        default: merge_word = memDataOut;
      endcase
    end else if (addr_q[1]) begin
      merge_word[31:16] = data_q[15:0];
    end else begin
      merge_word[15:0] = data_q[15:0];
    end
  end

  always_comb begin
    state_next     = state;
    reqReady       = 1'b0;
    memEnable      = 1'b0;
    memWriteEnable = 1'b0;
    memAddress     = {addr_q[31:2], 2'b00};
    memDataIn      = 32'h0;
    case (state)
      IDLE: begin
        reqReady   = 1'b1;
        memAddress = {reqAddress[31:2], 2'b00};
        memDataIn  = reqData;
        if (accept) begin
          if (fault) begin
            state_next = RESP;
          end else begin
            memEnable      = 1'b1;
            memWriteEnable = is_sw;
            if (!reqWrite)  state_next = LOAD;
            else if (is_sw) state_next = RESP;
            else            state_next = MERGE;
          end
        end
      end
      LOAD:  state_next = RESP;
      MERGE: begin
        memEnable      = 1'b1;
        memWriteEnable = 1'b1;
        memDataIn      = merge_word;
        state_next     = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Reset must cut a pending merge write in the same cycle, before the next edge.
    if (reset) begin
      reqReady       = 1'b0;
      memEnable      = 1'b0;
      memWriteEnable = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      addr_q    <= 32'h0;
      data_q    <= 32'h0;
      funct3_q  <= 3'b000;
      write_q   <= 1'b0;
      respData  <= 32'h0;
      respFault <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        addr_q   <= reqAddress;
        data_q   <= reqData;
        funct3_q <= reqFunct3;
        write_q  <= reqWrite;
        // Response registers change only on the edge that enters RESP.
        if (fault || is_sw) begin
          respData  <= 32'h0;
          respFault <= fault;
        end
      end
      if (state == LOAD) begin
        respData  <= load_result;
        respFault <= 1'b0;
      end
      if (state == MERGE) begin
        respData  <= 32'h0;
        respFault <= write_q ? 1'b0 : 1'b1;
      end
    end
  end

endmodule
